// File: rtl/spi_axi_pkg.sv
// Shared definitions for the SPI<->AXI bridge pair: word size, frame length,
// FSM encoding and a ceil-log2 helper.
package spi_axi_pkg;

  localparam int unsigned SWORD      = 32;
  localparam int unsigned FRAME_BITS = 2 * SWORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Number of bits needed to encode values 0 .. value-1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    clogb2 = 0;
    v      = value - 1;
    while (v > 0) begin
      clogb2 = clogb2 + 1;
      v      = v >> 1;
    end
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Synchronizes the SPI pad signals into the clk domain and detects edges on
// the synced SCLK and CEB against a one-cycle delayed copy.
module spi_rx_sync #(
  parameter int unsigned sync_stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic ceb,
  input  logic data,
  output logic sclk_rise,
  output logic ceb_rise,
  output logic ceb_fall,
  output logic ceb_s,
  output logic data_s
);

  localparam int unsigned MSB = sync_stages - 1;

  logic [sync_stages-1:0] sclk_ff;
  logic [sync_stages-1:0] ceb_ff;
  logic [sync_stages-1:0] data_ff;
  logic                   sclk_d;
  logic                   ceb_d;

  // CEB chain resets high so that leaving reset with CEB idle is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff <= '0;
      ceb_ff  <= '1;
      data_ff <= '0;
      sclk_d  <= 1'b0;
      ceb_d   <= 1'b1;
    end else begin
      sclk_ff <= {sclk_ff[sync_stages-2:0], sclk};
      ceb_ff  <= {ceb_ff[sync_stages-2:0], ceb};
      data_ff <= {data_ff[sync_stages-2:0], data};
      sclk_d  <= sclk_ff[MSB];
      ceb_d   <= ceb_ff[MSB];
    end
  end

  assign sclk_rise = sclk_ff[MSB] & ~sclk_d;
  assign ceb_rise  = ceb_ff[MSB] & ~ceb_d;
  assign ceb_fall  = ~ceb_ff[MSB] & ceb_d;
  assign ceb_s     = ceb_ff[MSB];
  assign data_s    = data_ff[MSB];

endmodule

// File: rtl/spi_axi_master.sv
// SPI slave receiver that turns each 2*sword-bit frame (address, then data)
// into a single AXI4-lite write.
module spi_axi_master
  import spi_axi_pkg::*;
#(
  parameter int unsigned sword       = SWORD,
  parameter int unsigned sync_stages = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLK,
  input  logic             CEB,
  input  logic             DATA,
  output logic             axi_awvalid,
  input  logic             axi_awready,
  output logic [sword-1:0] axi_awaddr,
  output logic [2:0]       axi_awprot,
  output logic             axi_wvalid,
  input  logic             axi_wready,
  output logic [sword-1:0] axi_wdata,
  output logic [3:0]       axi_wstrb,
  input  logic             axi_bvalid,
  output logic             axi_bready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned FB = 2 * sword;
  localparam int unsigned CW = clogb2(FB + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FB);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FB + 1);

  logic sclk_rise, ceb_rise, ceb_fall, ceb_s, data_s;

  spi_rx_sync #(.sync_stages(sync_stages)) u_sync (
    .clk      (CLK),
    .rst_n    (RST),
    .sclk     (SCLK),
    .ceb      (CEB),
    .data     (DATA),
    .sclk_rise(sclk_rise),
    .ceb_rise (ceb_rise),
    .ceb_fall (ceb_fall),
    .ceb_s    (ceb_s),
    .data_s   (data_s)
  );

  state_e           state_q, state_d;
  logic             aw_pend_q, aw_pend_d;
  logic             w_pend_q, w_pend_d;
  logic             bready_q, bready_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [sword-1:0] awaddr_q, awaddr_d;
  logic [sword-1:0] wdata_q, wdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FB-1:0]    shift_q, shift_d;
  logic             frame_ok;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_ok    = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Bit capture first so a frame-closing CEB rise sees the final bit.
    if (ceb_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise && !ceb_s) begin
      shift_d = {shift_q[FB-2:0], data_s};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end

    if (ceb_rise) begin
      frame_ok    = (cnt_d == CNT_FULL);
      frame_err_d = (cnt_d != CNT_FULL);
      overrun_d   = frame_ok && (state_q != IDLE);
    end

    case (state_q)
      IDLE: begin
        if (frame_ok) begin
          state_d   = WRITE;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          awaddr_d  = shift_d[FB-1:sword];
          wdata_d   = shift_d[sword-1:0];
        end
      end
      WRITE: begin
        aw_pend_d = aw_pend_q & ~axi_awready;
        w_pend_d  = w_pend_q & ~axi_wready;
        if (!aw_pend_d && !w_pend_d) state_d = RESP;
      end
      RESP: begin
        if (axi_bvalid && bready_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bready_d = (state_d == RESP);
    busy_d   = (state_d != IDLE);
  end

  assign axi_awvalid = aw_pend_q;
  assign axi_wvalid  = w_pend_q;
  assign axi_bready  = bready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_wdata   = wdata_q;
  assign axi_awprot  = 3'b000;
  assign axi_wstrb   = 4'b1111;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_axi_master.sv
// Directed + randomized bench for spi_axi_master: SPI host driver, AXI slave
// monitor and an expected-transaction reference built from the frame rules.
module tb_spi_axi_master;

  logic        CLK, RST, SCLK, CEB, DATA;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, busy, frame_err, overrun;
  logic [31:0] axi_awaddr, axi_wdata;
  logic [2:0]  axi_awprot;
  logic [3:0]  axi_wstrb;

  spi_axi_master #(.sword(32), .sync_stages(2)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CEB(CEB), .DATA(DATA),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, fe_cnt = 0, ov_cnt = 0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave-side monitor, sampled on the inactive edge.
  logic        aw_hold = 1'b0, w_hold = 1'b0;
  logic [31:0] aw_prev, w_prev;
  always @(negedge CLK) begin
    if (!RST) begin
      aw_hold = 1'b0;
      w_hold  = 1'b0;
    end else begin
      if (aw_hold) begin
        chk("awvalid_withdrawn", 64'(axi_awvalid), 64'd1);
        chk("awaddr_unstable", 64'(axi_awaddr), 64'(aw_prev));
      end
      if (w_hold) begin
        chk("wvalid_withdrawn", 64'(axi_wvalid), 64'd1);
        chk("wdata_unstable", 64'(axi_wdata), 64'(w_prev));
      end
      if (axi_bready) chk("bready_early", 64'(axi_awvalid | axi_wvalid), 64'd0);
      if (axi_awvalid && axi_awready) begin aw_q.push_back(axi_awaddr); aw_hs++; end
      if (axi_wvalid && axi_wready) begin w_q.push_back(axi_wdata); w_hs++; end
      if (axi_bvalid && axi_bready) b_hs++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      aw_hold = axi_awvalid & ~axi_awready;
      w_hold  = axi_wvalid & ~axi_wready;
      aw_prev = axi_awaddr;
      w_prev  = axi_wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // SPI host: CEB-high gap, then n bits MSB first with `half` CLK per phase.
  task automatic send_frame(input logic [79:0] bits, input int n, input int half);
    tick(half);
    CEB = 1'b0;
    tick(half);
    for (int i = n - 1; i >= 0; i--) begin
      DATA = bits[i];
      tick(half);
      SCLK = 1'b1;
      tick(half);
      SCLK = 1'b0;
    end
    tick(half);
    CEB = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick(1);
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_aw(input int budget);
    for (int i = 0; i < budget && !axi_awvalid; i++) tick(1);
    chk("awvalid_timeout", 64'(axi_awvalid), 64'd1);
  endtask

  task automatic expect_pair(input logic [31:0] a, input logic [31:0] d);
    chk("aw_count", 64'(aw_q.size()), 64'd1);
    chk("w_count", 64'(w_q.size()), 64'd1);
    if (aw_q.size() > 0) chk("awaddr", 64'(aw_q.pop_front()), 64'(a));
    if (w_q.size() > 0) chk("wdata", 64'(w_q.pop_front()), 64'(d));
    aw_q.delete();
    w_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x;
    logic [79:0] bits;
    int fe0, ov0, aw0, b0;

    RST = 1'b0; SCLK = 1'b0; CEB = 1'b1; DATA = 1'b0;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    tick(3);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_bready", 64'(axi_bready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({frame_err, overrun}), 64'd0);
    chk("rst_awaddr", 64'(axi_awaddr), 64'd0);
    chk("rst_wdata", 64'(axi_wdata), 64'd0);
    chk("rst_consts", 64'({axi_awprot, axi_wstrb}), 64'h0F);
    RST = 1'b1;
    tick(4);
    chk("post_rst_idle", 64'({busy, frame_err}), 64'd0);

    // Basic frame, SCLK = CLK/8.
    fe0 = fe_cnt; ov0 = ov_cnt; b0 = b_hs;
    bits = {16'h0, 32'h0000_1000, 32'hDEAD_BEEF};
    send_frame(bits, 64, 4);
    tick(4);
    wait_idle(100);
    expect_pair(32'h0000_1000, 32'hDEAD_BEEF);
    chk("basic_b_hs", 64'(b_hs - b0), 64'd1);
    chk("basic_errs", 64'((fe_cnt - fe0) + (ov_cnt - ov0)), 64'd0);

    // awready held off 5 cycles, wready immediate.
    axi_awready = 1'b0;
    bits = {16'h0, 32'hA5A5_0010, 32'h0BAD_F00D};
    send_frame(bits, 64, 4);
    wait_aw(50);
    chk("dly_wvalid_entry", 64'(axi_wvalid), 64'd1);
    tick(1);
    chk("dly_wvalid_drop", 64'(axi_wvalid), 64'd0);
    chk("dly_aw_hold", 64'(axi_awvalid), 64'd1);
    chk("dly_bready_lo", 64'(axi_bready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("dly_aw_hold", 64'(axi_awvalid), 64'd1);
      chk("dly_awaddr", 64'(axi_awaddr), 64'hA5A5_0010);
      chk("dly_bready_lo", 64'(axi_bready), 64'd0);
    end
    axi_awready = 1'b1;
    tick(1);
    chk("dly_aw_done", 64'(axi_awvalid), 64'd0);
    chk("dly_bready_hi", 64'(axi_bready), 64'd1);
    tick(1);
    chk("dly_idle", 64'(busy), 64'd0);
    expect_pair(32'hA5A5_0010, 32'h0BAD_F00D);

    // Short and long frames.
    fe0 = fe_cnt; aw0 = aw_hs;
    bits = {$urandom, $urandom, $urandom};
    send_frame(bits, 63, 4);
    tick(6);
    chk("short_busy", 64'(busy), 64'd0);
    send_frame(bits, 65, 4);
    tick(6);
    chk("long_busy", 64'(busy), 64'd0);
    chk("frame_err_pulses", 64'(fe_cnt - fe0), 64'd2);
    chk("err_no_aw", 64'(aw_hs - aw0), 64'd0);

    // Second frame while the response is pending.
    ov0 = ov_cnt; fe0 = fe_cnt; aw0 = aw_hs;
    axi_bvalid = 1'b0;
    bits = {16'h0, 32'h0000_2000, 32'h1111_2222};
    send_frame(bits, 64, 4);
    tick(6);
    chk("ovr_in_resp", 64'(axi_bready), 64'd1);
    bits = {16'h0, 32'h0000_3000, 32'h3333_4444};
    send_frame(bits, 64, 4);
    tick(6);
    chk("overrun_pulses", 64'(ov_cnt - ov0), 64'd1);
    axi_bvalid = 1'b1;
    wait_idle(20);
    chk("ovr_one_aw", 64'(aw_hs - aw0), 64'd1);
    chk("ovr_no_fe", 64'(fe_cnt - fe0), 64'd0);
    chk("ovr_awaddr_kept", 64'(axi_awaddr), 64'h0000_2000);
    chk("ovr_wdata_kept", 64'(axi_wdata), 64'h1111_2222);
    expect_pair(32'h0000_2000, 32'h1111_2222);

    // Reset during WRITE.
    axi_awready = 1'b0; axi_wready = 1'b0;
    bits = {16'h0, 32'hFFFF_0000, 32'h5555_AAAA};
    send_frame(bits, 64, 4);
    wait_aw(50);
    RST = 1'b0;
    #1;
    chk("rstmid_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rstmid_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    tick(2);
    RST = 1'b1;
    axi_awready = 1'b1; axi_wready = 1'b1;
    tick(2);
    chk("rstmid_no_hs", 64'(aw_q.size() + w_q.size()), 64'd0);
    bits = {16'h0, 32'h0000_0004, 32'h1234_5678};
    send_frame(bits, 64, 4);
    tick(4);
    wait_idle(50);
    expect_pair(32'h0000_0004, 32'h1234_5678);

    // Randomized frames from an xorshift64 stream at the fastest legal SCLK.
    fe0 = fe_cnt; ov0 = ov_cnt;
    x = {$urandom, $urandom} | 64'd1;
    for (int f = 0; f < 128; f++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 7);
      x = x ^ (x << 17);
      bits = {16'h0, x};
      send_frame(bits, 64, 3);
      tick(4);
      wait_idle(50);
      expect_pair(x[63:32], x[31:0]);
    end
    chk("rand_no_fe", 64'(fe_cnt - fe0), 64'd0);
    chk("rand_no_ovr", 64'(ov_cnt - ov0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
